// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM state type and default data-memory depth shared by the load/store unit files
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int MEM_WORDS_DEF = 256;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
endpackage

// File: rtl/lsu_lane_unit.sv
// lsu_lane_unit: combinational lane logic; word/offset/size/sgn/wdata in, load_data (zero/sign-extended lane) and store_word (wdata merged into word) out
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = word[{offset[1], 4'b0000} +: 16];
    load_data = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
                size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
    mask = (size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff) << {offset, 3'b000};
    store_word = (word & ~mask) | ((wdata << {offset, 3'b000}) & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator; req_* valid/ready request in, resp_* registered completion out, mem_* word-indexed memory port with RMW for sub-word stores; LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses fault instead of aligning
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);
  state_t state, next;
  logic accept, bad, misalign;
  logic [1:0] off_a;
  logic write_q, sgn_q, fault_q;
  logic [1:0] size_q, off_q;
  logic [31:0] wdata_q, rdata_q, load_data, store_word;
  assign req_ready = state == IDLE && !rst;
  assign accept = req_valid && req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  assign off_a = req_addr[1:0];
`else
  assign misalign = 1'b0;
  assign off_a = req_size == SZ_WORD ? 2'b00 : req_size == SZ_HALF ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif
  assign bad = req_size == 2'b11 || {2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS) || misalign;
  lsu_lane_unit u_lane (
    .word(mem_read_data),
    .offset(off_q),
    .size(size_q),
    .sgn(sgn_q),
    .wdata(wdata_q),
    .load_data(load_data),
    .store_word(store_word)
  );
  always_comb begin
    next = state == IDLE ? (accept ? (bad ? RESP : (req_write && req_size == SZ_WORD) ? WRITE : READ) : IDLE) :
           state == READ ? (write_q ? WRITE : RESP) :
           state == WRITE ? RESP : IDLE;
  end
  // responses are registered off the RESP state, so resp_valid rises as the FSM returns to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      mem_address <= '0;
      mem_write_en <= 1'b0;
      mem_write_data <= '0;
      write_q <= 1'b0;
      sgn_q <= 1'b0;
      fault_q <= 1'b0;
      size_q <= SZ_BYTE;
      off_q <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= next;
      resp_valid <= state == RESP;
      resp_fault <= state == RESP && fault_q;
      resp_rdata <= state == RESP ? rdata_q : '0;
      mem_write_en <= next == WRITE;
      if (accept) begin
        write_q <= req_write;
        sgn_q <= req_signed;
        size_q <= req_size;
        off_q <= off_a;
        wdata_q <= req_wdata;
        fault_q <= bad;
        rdata_q <= '0;
        if (!bad) mem_address <= {2'b00, req_addr[ADDR_W-1:2]};
      end
      if (state == IDLE && next == WRITE) mem_write_data <= req_wdata;
      if (state == READ) begin
        rdata_q <= write_q ? '0 : load_data;
        if (write_q) mem_write_data <= store_word;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a byte-addressed reference memory model
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [15:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [31:0] ram [0:255];
  logic [7:0]  mb [0:1023];
  int checks = 0;
  int errors = 0;
  logic [31:0] got_rdata, got_wdata, exp_rdata;
  logic got_fault, got_ready, exp_fault;
  int got_lat, got_wr, exp_lat, exp_wr;
  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_write_en && mem_address < 16'd256) ram[mem_address[7:0]] <= mem_write_data;
  assign mem_read_data = mem_address < 16'd256 ? ram[mem_address[7:0]] : 32'hDEADBEEF;

  // Reference: memory as 1024 little-endian bytes; applies the access and returns result/fault
  function automatic void model(input logic w, input logic [1:0] sz, input logic s, input logic [15:0] a0,
                                input logic [31:0] wd, output logic [31:0] rd, output logic f);
    int n, a;
    logic [31:0] v;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    a = int'(a0);
    rd = '0;
    f = 1'b0;
    if (sz == 2'd3) f = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    else if (a % n != 0) f = 1'b1;
`else
    else a = a - a % n;
`endif
    if (a / 4 >= 256) f = 1'b1;
    if (f) return;
    if (!w) begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8 * i));
      if (s && n < 4 && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
      rd = v;
    end else begin
      for (int i = 0; i < n; i++) mb[a + i] = wd[8 * i +: 8];
    end
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic s, input logic [15:0] a, input logic [31:0] wd);
    model(w, sz, s, a, wd, exp_rdata, exp_fault);
    exp_lat = exp_fault ? 1 : (w && sz != 2'd2) ? 3 : 2;
    exp_wr = (!exp_fault && w) ? 1 : 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req: got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_signed = s;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got_lat = 0;
    got_wr = 0;
    got_wdata = '0;
    forever begin
      if (mem_write_en === 1'b1) begin
        got_wr++;
        got_wdata = mem_write_data;
      end
      if (resp_valid === 1'b1 || got_lat == 8) break;
      @(posedge clk);
      #1;
      got_lat++;
    end
    if (resp_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: addr %h no resp_valid after %0d cycles", a, got_lat);
    end
    got_rdata = resp_rdata;
    got_fault = resp_fault;
    got_ready = req_ready;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    if (resp_valid !== 1'b0 || resp_fault !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got v=%b f=%b d=%h want 0", resp_valid, resp_fault, resp_rdata);
    end
    if (mem_write_en !== 1'b0 || mem_address !== 16'h0 || mem_write_data !== 32'h0) begin
      errors++; $display("FAIL reset_mem: got we=%b a=%h d=%h want 0", mem_write_en, mem_address, mem_write_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_load_word;
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
    checks += 3;
    if (got_rdata !== 32'h4) begin errors++; $display("FAIL lw_data: got %h want 00000004", got_rdata); end
    if (got_lat != 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", got_lat); end
    if (got_wr != 0) begin errors++; $display("FAIL lw_no_write: got %0d write cycles want 0", got_wr); end
  endtask

  task automatic test_misalign;
    do_req(1'b0, 2'd2, 1'b0, 16'h0013, 32'h0);
    checks += 3;
`ifdef LSU_MISALIGN_TRAP_EN
    if (got_fault !== 1'b1 || got_rdata !== 32'h0) begin
      errors++; $display("FAIL misalign_trap: got f=%b d=%h want f=1 d=0", got_fault, got_rdata);
    end
    if (got_lat != 1) begin errors++; $display("FAIL misalign_latency: got %0d want 1", got_lat); end
`else
    if (got_fault !== 1'b0 || got_rdata !== 32'h4) begin
      errors++; $display("FAIL misalign_align: got f=%b d=%h want f=0 d=00000004", got_fault, got_rdata);
    end
    if (got_lat != 2) begin errors++; $display("FAIL misalign_latency: got %0d want 2", got_lat); end
`endif
    if (got_wr != 0) begin errors++; $display("FAIL misalign_no_write: got %0d want 0", got_wr); end
  endtask

  task automatic test_store_and_subword_loads;
    do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'h80817F80);
    checks += 4;
    if (got_lat != 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", got_lat); end
    if (got_wr != 1 || got_wdata !== 32'h80817F80) begin
      errors++; $display("FAIL sw_write: got %0d cycles d=%h want 1 cycle d=80817f80", got_wr, got_wdata);
    end
    if (got_rdata !== 32'h0 || got_fault !== 1'b0) begin
      errors++; $display("FAIL sw_resp: got d=%h f=%b want 0", got_rdata, got_fault);
    end
    if (ram[4] !== 32'h80817F80) begin errors++; $display("FAIL sw_mem: got %h want 80817f80", ram[4]); end
    do_req(1'b0, 2'd0, 1'b1, 16'h0010, 32'h0);
    checks++;
    if (got_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h want ffffff80", got_rdata); end
    do_req(1'b0, 2'd0, 1'b0, 16'h0011, 32'h0);
    checks++;
    if (got_rdata !== 32'h0000007F) begin errors++; $display("FAIL lbu: got %h want 0000007f", got_rdata); end
    do_req(1'b0, 2'd1, 1'b1, 16'h0012, 32'h0);
    checks++;
    if (got_rdata !== 32'hFFFF8081) begin errors++; $display("FAIL lh_signed: got %h want ffff8081", got_rdata); end
  endtask

  task automatic test_store_byte;
    do_req(1'b1, 2'd0, 1'b0, 16'h0021, 32'h000000AB);
    checks += 2;
    if (got_wr != 1 || got_wdata !== 32'h0000AB08) begin
      errors++; $display("FAIL sb_merge: got %0d cycles d=%h want 1 cycle d=0000ab08", got_wr, got_wdata);
    end
    if (got_lat != 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", got_lat); end
  endtask

  task automatic test_faults;
    do_req(1'b1, 2'd2, 1'b0, 16'h0400, 32'h12345678);
    checks += 2;
    if (got_fault !== 1'b1 || got_rdata !== 32'h0 || got_lat != 1) begin
      errors++; $display("FAIL range_fault: got f=%b d=%h lat=%0d want f=1 d=0 lat=1", got_fault, got_rdata, got_lat);
    end
    if (got_wr != 0) begin errors++; $display("FAIL range_no_write: got %0d want 0", got_wr); end
    do_req(1'b1, 2'd3, 1'b0, 16'h0008, 32'hCAFEF00D);
    checks += 2;
    if (got_fault !== 1'b1 || got_lat != 1) begin
      errors++; $display("FAIL size_fault: got f=%b lat=%0d want f=1 lat=1", got_fault, got_lat);
    end
    if (got_wr != 0 || ram[2] !== 32'h2) begin
      errors++; $display("FAIL size_no_write: got %0d cycles ram2=%h want 0 cycles ram2=2", got_wr, ram[2]);
    end
  endtask

  task automatic test_rst_mid;
    int seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size = 2'd2;
    req_addr = 16'h0010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks += 3;
    if (resp_valid !== 1'b0 || mem_write_en !== 1'b0 || mem_address !== 16'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got v=%b we=%b a=%h want 0", resp_valid, mem_write_en, mem_address);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (resp_valid === 1'b1) seen++;
    end
    if (seen != 0) begin errors++; $display("FAIL rst_mid_stray_resp: got %0d pulses want 0", seen); end
    do_req(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0);
    checks++;
    if (got_rdata !== 32'h0 || got_fault !== 1'b0) begin
      errors++; $display("FAIL rst_mid_followup: got d=%h f=%b want 0", got_rdata, got_fault);
    end
  endtask

  task automatic test_back_to_back;
    do_req(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0);
    checks++;
    if (got_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_resp: got %b want 1", got_ready); end
    do_req(1'b0, 2'd1, 1'b0, 16'h0022, 32'h0);
    checks++;
    if (got_rdata !== exp_rdata || got_lat != 2) begin
      errors++; $display("FAIL b2b_second: got d=%h lat=%0d want d=%h lat=2", got_rdata, got_lat, exp_rdata);
    end
  endtask

  task automatic test_random;
    logic [1:0] sz;
    int bad;
    for (int k = 0; k < 150; k++) begin
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'h047F)), $urandom);
      checks += 4;
      if (got_rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, got_rdata, exp_rdata); end
      if (got_fault !== exp_fault) begin errors++; $display("FAIL rand_fault[%0d]: got %b want %b", k, got_fault, exp_fault); end
      if (got_lat != exp_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, got_lat, exp_lat); end
      if (got_wr != exp_wr) begin errors++; $display("FAIL rand_writes[%0d]: got %0d want %0d", k, got_wr, exp_wr); end
    end
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]}) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL final_memory: got %0d differing words want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'(i);
      for (int j = 0; j < 4; j++) mb[4*i+j] = j == 0 ? 8'(i) : 8'h00;
    end
    test_reset;
    test_load_word;
    test_misalign;
    test_store_and_subword_loads;
    test_store_byte;
    test_faults;
    test_rst_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface for the multicycle CPU.
- Accepts byte, half and word load/store requests from the control path over a valid/ready handshake.
- Translates byte addresses to data-memory word indices, drives the memory's address, write-enable and write-data port, and extracts/sign-extends load data.
- Performs read-modify-write for sub-word stores, because the memory only writes whole 32-bit words.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the attached data memory; word indices >= MEM_WORDS fault.
- ADDR_W, 16, width of the byte address and of the memory word-index port.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready at posedge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend load result (ignored for word/store)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (0 for stores/faults)
- resp_fault  out  1  access faulted, memory not written
- mem_address  out  ADDR_W  word index to data memory
- mem_write_en  out  1  memory write strobe
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read data from memory

Behaviour:
- One clock (clk); synchronous active-high reset (rst). All outputs registered except req_ready = (state == IDLE) && !rst.
- Reset: state IDLE; resp_valid 0, resp_rdata 0, resp_fault 0, mem_write_en 0, mem_address 0, mem_write_data 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE, on accept: latch addr, size, signed and wdata; word index = addr[ADDR_W-1:2].
  - Fault if size == 11, index >= MEM_WORDS, or misaligned (see Optional Feature). Fault -> RESP with fault=1, rdata=0, no memory access.
  - Load or sub-word store -> READ.
  - Word store -> WRITE.
- READ: mem_address = index, mem_write_en = 0. Capture mem_read_data at the end of the cycle.
  - Load -> RESP with the extracted lane.
  - Sub-word store -> WRITE with the merged word.
- WRITE: mem_write_en = 1 for exactly one cycle; mem_address and mem_write_data stable for that whole cycle. -> RESP.
- RESP: resp_valid = 1 for one cycle -> IDLE. mem_write_en is 0 in every state except WRITE.
- Latency from the accept edge to resp_valid high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Byte/half store: 3 cycles.
  - Fault: 1 cycle.
- Byte lanes are little-endian: byte at addr[1:0]=0 is bits 7:0; half at addr[1]=0 is bits 15:0.
- Load extraction: zero-extend, or sign-extend when req_signed=1.
- Store merge: replace only the addressed lane(s) with wdata low bits; other lanes keep the read word.
- req_valid is ignored outside IDLE; no queueing. The next request is accepted no earlier than the cycle after RESP.
- rst mid-operation: the next posedge returns to IDLE with all outputs at reset values and no resp_valid. If rst is asserted during a WRITE cycle, that write still lands, because mem_write_en was already registered high.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 faults (resp_fault=1, rdata=0, no write).
- Undefined: low address bits are forced to alignment (half clears bit 0, word clears bits 1:0) and the access completes normally with resp_fault=0.

Decomposition:
- Package lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, default MEM_WORDS.
- One combinational sub-module, lsu_lane_unit: takes word, offset, size, signed and wdata; outputs extracted load data and merged store word. Verified standalone.

Test Plan:
- Memory initialised ram[i]=i; load word 0x0010 -> index 4, resp_rdata 0x00000004, resp_valid 2 cycles after accept, mem_write_en never high.
- Store word 0x80817F80 to 0x0010, then:
  - load byte signed 0x0010 -> 0xFFFFFF80
  - load byte unsigned 0x0011 -> 0x0000007F
  - load half signed 0x0012 -> 0xFFFF8081
- Store byte 0xAB to 0x0021 (index 8 holds 8) -> READ then a single WRITE cycle with mem_write_data 0x0000AB08; resp 3 cycles after accept.
- Load word 0x0013: with LSU_MISALIGN_TRAP_EN -> resp_fault=1, rdata 0, 1-cycle latency; without -> rdata 0x00000004, fault 0.
- Store word to 0x0400 (index 256) and req_size=11 -> resp_fault=1, mem_write_en stays 0, memory unchanged.
- Assert rst during READ of a load -> IDLE next cycle, no resp_valid, req_ready high after rst deasserts; a following load of 0x0000 returns 0x00000000.
